// File: rtl/box_plotter.sv
// Box plotter: streams a clipped w x h box (optionally outline only via BOX_PLOTTER_OUTLINE_EN) to the VGA write port in raster order.
// Latency: first pixel one cycle after start; done pulses one cycle after the last pixel. Pixels are held while plot_ready is low.
module box_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int SIZE_W   = 5,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic [SIZE_W-1:0] w_in,
    input  logic [SIZE_W-1:0] h_in,
    input  logic [C_W-1:0]    colour_in,
    input  logic              plot_ready,
`ifdef BOX_PLOTTER_OUTLINE_EN
    input  logic              outline,
`endif
    output logic              busy,
    output logic              done,
    output logic              plot,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [C_W-1:0]    colour_out
);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x0_q, x0_d;
    logic [Y_W-1:0]    y0_q, y0_d;
    logic [SIZE_W-1:0] w_q, w_d, h_q, h_d;
    logic [SIZE_W-1:0] col_q, col_d, row_q, row_d;
    logic [C_W-1:0]    colour_q, colour_d;
    logic              outline_q, outline_d;

    logic [X_W:0]      px;
    logic [Y_W:0]      py;
    logic              clipped, last_col, last_row, border_row, advance;

    // One extra bit on each sum so an origin near the top of the range cannot wrap back on screen.
    assign px = {1'b0, x0_q} + (X_W+1)'(col_q);
    assign py = {1'b0, y0_q} + (Y_W+1)'(row_q);

    assign clipped    = px[X_W] || py[Y_W] ||
                        (px >= (X_W+1)'(SCREEN_W)) || (py >= (Y_W+1)'(SCREEN_H));
    assign last_col   = (col_q == w_q - SIZE_W'(1));
    assign last_row   = (row_q == h_q - SIZE_W'(1));
    assign border_row = (row_q == '0) || last_row;
    assign advance    = (state_q == DRAW) && (clipped || plot_ready);

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        colour_d  = colour_q;
        outline_d = outline_q;
        col_d     = col_q;
        row_d     = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d     = x_in;
                    y0_d     = y_in;
                    w_d      = w_in;
                    h_d      = h_in;
                    colour_d = colour_in;
`ifdef BOX_PLOTTER_OUTLINE_EN
                    outline_d = outline;
`else
                    outline_d = 1'b0;
`endif
                    col_d    = '0;
                    row_d    = '0;
                    state_d  = (w_in == '0 || h_in == '0) ? FIN : DRAW;
                end
            end
            DRAW: begin
                if (advance) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = FIN;
                        end else begin
                            row_d = row_q + SIZE_W'(1);
                        end
                    end else if (outline_q && !border_row && col_q == '0) begin
                        // Interior of an outline row: skip straight to the right edge.
                        col_d = w_q - SIZE_W'(1);
                    end else begin
                        col_d = col_q + SIZE_W'(1);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            colour_q  <= '0;
            outline_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            colour_q  <= colour_d;
            outline_q <= outline_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    assign busy       = (state_q == DRAW);
    assign done       = (state_q == FIN);
    assign plot       = (state_q == DRAW) && !clipped;
    assign x_out      = plot ? px[X_W-1:0] : '0;
    assign y_out      = plot ? py[Y_W-1:0] : '0;
    assign colour_out = plot ? colour_q : '0;

endmodule

// File: tb/tb_box_plotter.sv
// Directed bench for box_plotter: filled, backpressured, clipped, degenerate, ignored-start, reset-abort and outline boxes.
module tb_box_plotter;
    localparam int X_W = 8, Y_W = 7, C_W = 3, SIZE_W = 5;

    logic              clk = 1'b0;
    logic              resetn, start, plot_ready;
    logic [X_W-1:0]    x_in;
    logic [Y_W-1:0]    y_in;
    logic [SIZE_W-1:0] w_in, h_in;
    logic [C_W-1:0]    colour_in;
    logic              busy, done, plot;
    logic [X_W-1:0]    x_out;
    logic [Y_W-1:0]    y_out;
    logic [C_W-1:0]    colour_out;
`ifdef BOX_PLOTTER_OUTLINE_EN
    logic              outline;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ex[$];
    int ey[$];

    always #5 clk = ~clk;

    box_plotter dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in),
        .colour_in(colour_in), .plot_ready(plot_ready),
`ifdef BOX_PLOTTER_OUTLINE_EN
        .outline(outline),
`endif
        .busy(busy), .done(done), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_box(input int x, input int y, input int w, input int h, input int c,
                           input bit ol, input bit bp, input bit mid_start,
                           input int exp_done, input string tag);
        int  idx, n, last_acc;
        bit  got_done;
        ex.delete();
        ey.delete();
        for (int r = 0; r < h; r++)
            for (int cc = 0; cc < w; cc++)
                if (!ol || r == 0 || r == h-1 || cc == 0 || cc == w-1)
                    if (x + cc < 160 && y + r < 120) begin
                        ex.push_back(x + cc);
                        ey.push_back(y + r);
                    end
        n = ex.size();
        @(negedge clk);
        start      = 1'b1;
        x_in       = X_W'(x);
        y_in       = Y_W'(y);
        w_in       = SIZE_W'(w);
        h_in       = SIZE_W'(h);
        colour_in  = C_W'(c);
        plot_ready = 1'b1;
`ifdef BOX_PLOTTER_OUTLINE_EN
        outline    = ol;
`endif
        idx = 0; last_acc = 0; got_done = 0;
        for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
            @(negedge clk);
            start      = mid_start && (cyc == 3);
            x_in       = X_W'($urandom);
            y_in       = Y_W'($urandom);
            w_in       = SIZE_W'($urandom);
            h_in       = SIZE_W'($urandom);
            colour_in  = C_W'($urandom);
            plot_ready = bp ? (cyc % 2 == 0) : 1'b1;
            if (done) begin
                got_done = 1;
                check({tag, "_done_cycle"}, cyc, exp_done);
                check({tag, "_busy_at_done"}, busy, 0);
                check({tag, "_plot_at_done"}, plot, 0);
                check({tag, "_pixel_count"}, idx, n);
                if (bp) check({tag, "_done_after_last_accept"}, cyc, last_acc + 1);
            end else begin
                check({tag, "_busy"}, busy, 1);
                if (plot) begin
                    if (idx < n) begin
                        check({tag, "_x"}, x_out, ex[idx]);
                        check({tag, "_y"}, y_out, ey[idx]);
                        check({tag, "_colour"}, colour_out, c);
                    end else begin
                        check({tag, "_extra_pixel"}, 1, 0);
                    end
                    if (plot_ready) begin
                        idx++;
                        last_acc = cyc;
                    end
                end
            end
        end
        if (!got_done) check({tag, "_timeout"}, 0, 1);
        start      = 1'b0;
        plot_ready = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; plot_ready = 1'b1;
        x_in = '0; y_in = '0; w_in = '0; h_in = '0; colour_in = '0;
`ifdef BOX_PLOTTER_OUTLINE_EN
        outline = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_colour", colour_out, 0);
        resetn = 1'b1;

        run_box(10, 20, 4, 4, 5, 0, 0, 0, 17, "fill");
        run_box(10, 20, 4, 4, 5, 0, 1, 0, 33, "bp");
        run_box(158, 118, 4, 4, 2, 0, 0, 0, 17, "clip");
        run_box(50, 60, 0, 5, 7, 0, 0, 0, 1, "zero");
        run_box(30, 40, 3, 3, 6, 0, 0, 1, 10, "midstart");

        // Abort a 4x4 box after its fifth pixel is shown.
        @(negedge clk);
        start = 1'b1; x_in = 8'd10; y_in = 7'd20; w_in = 5'd4; h_in = 5'd4; colour_in = 3'd5;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            check("abort_plot", plot, 1);
            check("abort_x", x_out, (cyc <= 4) ? 9 + cyc : 10);
            check("abort_y", y_out, (cyc <= 4) ? 20 : 21);
        end
        resetn = 1'b0;
        @(negedge clk);
        check("abort_plot_low", plot, 0);
        check("abort_busy_low", busy, 0);
        check("abort_done_low", done, 0);
        check("abort_x_zero", x_out, 0);
        check("abort_y_zero", y_out, 0);
        check("abort_colour_zero", colour_out, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
        run_box(5, 5, 2, 2, 1, 0, 0, 0, 5, "after_abort");

`ifdef BOX_PLOTTER_OUTLINE_EN
        run_box(0, 0, 4, 4, 4, 1, 0, 0, 13, "outline");
        run_box(20, 20, 3, 1, 3, 1, 0, 0, 4, "outline_h1");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
